mem_access_unit: RTL



---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_lane_align.sv | 48 ++++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store engine: RV32I funct3 codes,
// FSM state encoding and the byte-offset width inside a word.
package mem_pkg;

   localparam int OFF_W = 2;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD      = 3'd1,
      RD_WAIT = 3'd2,
      WR      = 3'd3,
      RESP    = 3'd4
   } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts and extends a load value from a memory
// word, and builds the merged word for a sub-word read-modify-write store.
module mem_lane_align
   import mem_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0]     word,
   input  logic [OFF_W-1:0] offset,
   input  logic [2:0]       funct3,
   input  logic [W-1:0]     wdata,
   output logic [W-1:0]     load_val,
   output logic [W-1:0]     merged
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{offset, 3'b000} +: 8];
      // Halfword lanes ignore offset[0]; a misaligned H folds down to its half.
      half_sel = offset[1] ? word[31:16] : word[15:0];
      load_val = word;
      merged   = wdata;

      case (funct3)
         F3_B:    load_val = {{(W-8){byte_sel[7]}}, byte_sel};
         F3_BU:   load_val = {{(W-8){1'b0}}, byte_sel};
         F3_H:    load_val = {{(W-16){half_sel[15]}}, half_sel};
         F3_HU:   load_val = {{(W-16){1'b0}}, half_sel};
         default: load_val = word;
      endcase

      case (funct3)
         F3_B: begin
            merged = word;
            merged[{offset, 3'b000} +: 8] = wdata[7:0];
         end
         F3_H: begin
            merged = word;
            if (offset[1]) merged[31:16] = wdata[15:0];
            else           merged[15:0]  = wdata[15:0];
         end
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine between execute stage and word-wide data memory; sub-word
// stores are read-modify-write. Build option: MEM_ACCESS_MISALIGN_TRAP_EN.
//
// state   | meaning
// IDLE    | ready for a request
// RD      | memory read strobe
// RD_WAIT | read data on i_mem_data; extend load or merge store word
// WR      | memory write strobe with final word
// RESP    | one-cycle response pulse
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int W = 32,
   parameter int D = 8
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_req_valid,
   output logic         o_req_ready,
   input  logic         i_req_write,
   input  logic [2:0]   i_req_funct3,
   input  logic [D-1:0] i_req_addr,
   input  logic [W-1:0] i_req_wdata,
   output logic         o_rsp_valid,
   output logic [W-1:0] o_rsp_data,
   output logic         o_rsp_err,
   output logic [D-1:0] o_mem_addr,
   output logic [W-1:0] o_mem_data,
   output logic         o_mem_read,
   output logic         o_mem_write,
   input  logic [W-1:0] i_mem_data
);

   state_t       state_q, state_d;
   logic [D-1:0] addr_q;
   logic [2:0]   f3_q;
   logic         write_q;
   logic         err_q;
   logic [W-1:0] wdata_q;
   logic [W-1:0] rsp_data_q;
   logic         accept;
   logic         req_illegal;
   logic         req_misalign;
   logic         req_err;
   logic [W-1:0] load_val;
   logic [W-1:0] merged;

   assign accept      = i_req_valid && (state_q == IDLE);
   assign req_illegal = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110) ||
                        (i_req_funct3 == 3'b111) || (i_req_write && i_req_funct3[2]);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   assign req_misalign = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                         ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
   assign req_misalign = 1'b0;
`endif
   assign req_err = req_illegal || req_misalign;

   mem_lane_align #(.W(W)) u_align (
      .word     (i_mem_data),
      .offset   (addr_q[OFF_W-1:0]),
      .funct3   (f3_q),
      .wdata    (wdata_q),
      .load_val (load_val),
      .merged   (merged)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      o_req_ready = 1'b0;
      o_rsp_valid = 1'b0;
      o_rsp_err   = 1'b0;
      o_mem_read  = 1'b0;
      o_mem_write = 1'b0;
      case (state_q)
         IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               if (req_err)                                 state_d = RESP;
               else if (i_req_write && i_req_funct3 == F3_W) state_d = WR;
               else                                         state_d = RD;
            end
         end
         RD: begin
            o_mem_read = 1'b1;
            state_d    = RD_WAIT;
         end
         RD_WAIT: state_d = write_q ? WR : RESP;
         WR: begin
            o_mem_write = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            o_rsp_valid = 1'b1;
            o_rsp_err   = err_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // wdata_q doubles as the merge buffer so WR always drives it unchanged.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         addr_q     <= '0;
         f3_q       <= '0;
         write_q    <= 1'b0;
         err_q      <= 1'b0;
         wdata_q    <= '0;
         rsp_data_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= i_req_addr;
            f3_q    <= i_req_funct3;
            write_q <= i_req_write;
            wdata_q <= i_req_wdata;
            err_q   <= req_err;
            if (req_err) rsp_data_q <= '0;
         end
         if (state_q == RD_WAIT) begin
            if (write_q) wdata_q    <= merged;
            else         rsp_data_q <= load_val;
         end
         if (state_q == WR) rsp_data_q <= '0;
      end
   end

   assign o_rsp_data = rsp_data_q;
   assign o_mem_addr = {addr_q[D-1:OFF_W], {OFF_W{1'b0}}};
   assign o_mem_data = wdata_q;

endmodule
